trace_scorer: RTL and testbench
===============================

TRACE_SCORER -- requirements
Module: trace_scorer

Interface
REQ-001 Parameter ROUND_TICKS, default 32'd250000000, tracing window in clk cycles.
REQ-002 Parameter HOLD_TICKS, default 32'd50000000, post-round display hold in clk cycles.
REQ-003 clk  input  1  system clock; all state changes on posedge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  one-cycle pulse requesting a new round.
REQ-006 score_clear  input  1  synchronous clear of the accumulated score.
REQ-007 displayed_trace  input  16  target boxes for the current round, bit i = box i.
REQ-008 already_traced  input  16  boxes the player has traced, from the grid display stage.
REQ-009 snitch_location  input  16  one-hot snitch box.
REQ-010 reset_trace  output  1  one-cycle pulse telling the grid stage to clear already_traced.
REQ-011 round_done  output  1  one-cycle pulse when a round is scored.
REQ-012 result  output  2  last round outcome: 0 none, 1 perfect, 2 sloppy, 3 timeout.
REQ-013 score  output  8  accumulated score, saturating.
REQ-014 hits  output  5  popcount(already_traced & displayed_trace), registered.
REQ-015 misses  output  5  popcount(already_traced & ~displayed_trace), registered.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 FSM states IDLE, CLEAR, TRACING, SCORE, HOLD; all outputs registered.
REQ-018 IDLE: start=1 -> CLEAR; start is ignored in all other states.
REQ-019 Entry to CLEAR: reset_trace=1 for exactly one cycle; target latched from displayed_trace on the start cycle.
REQ-020 CLEAR -> TRACING on the first cycle already_traced==0; the timer loads ROUND_TICKS-1 on that transition.
REQ-021 Latched target==0: CLEAR -> SCORE directly, result=3, no points.
REQ-022 TRACING: hits and misses update every cycle; the timer decrements by 1 per cycle.
REQ-023 Complete: (already_traced & target)==target -> SCORE.
REQ-024 Timeout: timer==0 and not complete -> SCORE; completion takes priority on the same cycle.
REQ-025 SCORE lasts one cycle: round_done=1 and result is updated.
REQ-026 Points awarded in SCORE: complete with misses==0 -> result 1, +10; complete with misses>0 -> result 2, +5; timeout -> result 3, +0.
REQ-027 Score arithmetic is 9-bit internally, and the result saturates at 255.
REQ-028 SCORE -> HOLD, counting HOLD_TICKS cycles -> IDLE; result persists until the next SCORE.
REQ-029 score_clear zeroes score in any state.
REQ-030 score_clear in the SCORE cycle: the clear wins and the round's points are discarded.
REQ-031 start and score_clear together in IDLE: both take effect.
REQ-032 Target bits change mid-round: ignored; the latched target is used.

Reset
REQ-033 rst_n=0 forces IDLE, timer=0, target=0, score=0, hits=0, misses=0, result=0, reset_trace=0, round_done=0, busy=0, immediately and independent of clk.
REQ-034 Reset mid-round abandons the round without a round_done pulse.
REQ-035 Release of rst_n is synchronous to clk.

Configuration
REQ-036 Macro TRACE_SCORER_SNITCH_BONUS_EN.
REQ-037 Defined: a perfect round whose already_traced & snitch_location is nonzero at SCORE earns +15 instead of +10.
REQ-038 Not defined: snitch_location is unused and a perfect round is always +10.

Verification
REQ-039 ROUND_TICKS=100: start with target 16'h000F, already_traced driven 0 then 16'h000F -> reset_trace one pulse, round_done, result=1, score=10, hits=4, misses=0.
REQ-040 Target 16'h0003, already_traced 16'h0007 -> result=2, score +5, misses=1.
REQ-041 Target 16'h0003, already_traced held at 16'h0001 for 100 cycles -> round_done on timeout, result=3, score unchanged.
REQ-042 Score preset to 250 via repeated perfect rounds -> next perfect round gives score=255, then score_clear gives 0.
REQ-043 With macro defined: target 16'h8001, snitch_location 16'h8000, perfect trace -> +15; without macro, same stimulus -> +10.
REQ-044 rst_n pulled low mid-TRACING -> all outputs reset asynchronously, no round_done, and a later start runs normally.

Source files
------------

// File: rtl/trace_scorer.sv
// trace_scorer: runs one tracing round per start pulse and scores it.
//   A round latches its target boxes, asks the grid stage to clear its
//   trace, then waits until every target box is traced or the timer runs
//   out. The round is then scored and the outcome is held for display.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   i_start                 one-cycle new-round request (honoured in IDLE only)
//   i_score_clear           synchronous clear of the accumulated score
//   i_displayed_trace[15:0] target boxes, latched on the start cycle
//   i_already_traced[15:0]  boxes traced so far, from the grid stage
//   i_snitch_location[15:0] one-hot snitch box (bonus build only)
//   o_reset_trace           one-cycle pulse: grid stage clears its trace
//   o_round_done            one-cycle pulse after a round is scored
//   o_result[1:0]           last outcome: 0 none, 1 perfect, 2 sloppy, 3 timeout
//   o_score[7:0]            accumulated score, saturating at 255
//   o_hits[4:0]             traced target boxes, registered
//   o_misses[4:0]           traced non-target boxes, registered
//   o_busy                  high whenever a round is in progress or held
// Build option: TRACE_SCORER_SNITCH_BONUS_EN makes a perfect round that
//   traced the snitch box worth 15 points instead of 10.
module trace_scorer #(
  parameter logic [31:0] ROUND_TICKS = 32'd250000000,
  parameter logic [31:0] HOLD_TICKS  = 32'd50000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic        i_score_clear,
  input  logic [15:0] i_displayed_trace,
  input  logic [15:0] i_already_traced,
  input  logic [15:0] i_snitch_location,
  output logic        o_reset_trace,
  output logic        o_round_done,
  output logic [1:0]  o_result,
  output logic [7:0]  o_score,
  output logic [4:0]  o_hits,
  output logic [4:0]  o_misses,
  output logic        o_busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_TRACING,
    S_SCORE,
    S_HOLD
  } state_t;

  localparam logic [1:0] RES_PERFECT = 2'd1;
  localparam logic [1:0] RES_SLOPPY  = 2'd2;
  localparam logic [1:0] RES_TIMEOUT = 2'd3;

  state_t      r_state;
  logic [31:0] r_timer;
  logic [15:0] r_target;
  logic        r_timeout;
  logic        r_reset_trace;
  logic        r_round_done;
  logic [1:0]  r_result;
  logic [7:0]  r_score;
  logic [4:0]  r_hits;
  logic [4:0]  r_misses;
  logic        r_busy;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) c = c + 5'(v[i]);
    return c;
  endfunction

  logic [4:0] w_hits_now;
  logic [4:0] w_misses_now;
  logic       w_complete;
  logic [7:0] w_perfect_pts;
  logic [7:0] w_points;
  logic [1:0] w_result;
  logic [8:0] w_sum;
  logic [7:0] w_score_next;

  assign w_hits_now   = popcount16(i_already_traced & r_target);
  assign w_misses_now = popcount16(i_already_traced & ~r_target);
  assign w_complete   = ((i_already_traced & r_target) == r_target);

`ifdef TRACE_SCORER_SNITCH_BONUS_EN
  // Snitch bonus is judged on the trace as it stands in the SCORE cycle.
  assign w_perfect_pts = (|(i_already_traced & i_snitch_location)) ? 8'd15 : 8'd10;
`else
  logic w_unused_snitch;
  assign w_unused_snitch = ^i_snitch_location;
  assign w_perfect_pts   = 8'd10;
`endif

  // Outcome of the round being scored; misses were registered on the exit edge of TRACING.
  always_comb begin
    w_result = RES_TIMEOUT;
    w_points = 8'd0;
    if (!r_timeout) begin
      if (r_misses == 5'd0) begin
        w_result = RES_PERFECT;
        w_points = w_perfect_pts;
      end else begin
        w_result = RES_SLOPPY;
        w_points = 8'd5;
      end
    end
  end

  assign w_sum        = 9'(r_score) + 9'(w_points);
  assign w_score_next = w_sum[8] ? 8'hFF : w_sum[7:0];

  // Round sequencer with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_timer       <= '0;
      r_target      <= '0;
      r_timeout     <= 1'b0;
      r_reset_trace <= 1'b0;
      r_round_done  <= 1'b0;
      r_result      <= '0;
      r_score       <= '0;
      r_hits        <= '0;
      r_misses      <= '0;
      r_busy        <= 1'b0;
    end else begin
      r_reset_trace <= 1'b0;
      r_round_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_target      <= i_displayed_trace;
            r_reset_trace <= 1'b1;
            r_busy        <= 1'b1;
            r_state       <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          // An empty target can never be completed; score it as a timeout.
          if (r_target == 16'd0) begin
            r_timeout <= 1'b1;
            r_state   <= S_SCORE;
          end else if (i_already_traced == 16'd0) begin
            r_timer <= ROUND_TICKS - 32'd1;
            r_state <= S_TRACING;
          end
        end
        S_TRACING: begin
          r_hits   <= w_hits_now;
          r_misses <= w_misses_now;
          if (w_complete) begin
            r_timeout <= 1'b0;
            r_state   <= S_SCORE;
          end else if (r_timer == 32'd0) begin
            r_timeout <= 1'b1;
            r_state   <= S_SCORE;
          end else begin
            r_timer <= r_timer - 32'd1;
          end
        end
        S_SCORE: begin
          r_round_done <= 1'b1;
          r_result     <= w_result;
          r_score      <= w_score_next;
          r_timer      <= HOLD_TICKS - 32'd1;
          r_state      <= S_HOLD;
        end
        S_HOLD: begin
          if (r_timer == 32'd0) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_timer <= r_timer - 32'd1;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
      // Placed last so a clear overrides points being added in SCORE.
      if (i_score_clear) r_score <= '0;
    end
  end

  assign o_reset_trace = r_reset_trace;
  assign o_round_done  = r_round_done;
  assign o_result      = r_result;
  assign o_score       = r_score;
  assign o_hits        = r_hits;
  assign o_misses      = r_misses;
  assign o_busy        = r_busy;

endmodule

// File: tb/tb_trace_scorer.sv
// Directed bench for trace_scorer with a short round and hold window.
module tb_trace_scorer;

  localparam logic [31:0] ROUND = 32'd100;
  localparam logic [31:0] HOLD  = 32'd4;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        score_clear;
  logic [15:0] displayed;
  logic [15:0] already;
  logic [15:0] snitch;
  logic        reset_trace;
  logic        round_done;
  logic [1:0]  result;
  logic [7:0]  score;
  logic [4:0]  hits;
  logic [4:0]  misses;
  logic        busy;

  int n_cmp;
  int n_err;
  int exp_score;
  int bonus;

  trace_scorer #(
    .ROUND_TICKS(ROUND),
    .HOLD_TICKS (HOLD)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_start          (start),
    .i_score_clear    (score_clear),
    .i_displayed_trace(displayed),
    .i_already_traced (already),
    .i_snitch_location(snitch),
    .o_reset_trace    (reset_trace),
    .o_round_done     (round_done),
    .o_result         (result),
    .o_score          (score),
    .o_hits           (hits),
    .o_misses         (misses),
    .o_busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int sat_add(input int s, input int p);
    return (s + p > 255) ? 255 : s + p;
  endfunction

  // Runs one round; the bench plays the grid stage, clearing its trace on
  // reset_trace and presenting trc on the following cycle. All sampling and
  // driving happens on negedges. done_at is the cycle index of round_done
  // counted from the first negedge after the start pulse.
  task automatic run_round(input logic [15:0] tgt, input logic [15:0] trc,
                           input logic [15:0] snt, input bit clr_with_start,
                           input int clr_at, input int max_cyc,
                           output int done_at, output int rt_pulses,
                           output bit busy_seen, output int hold_cnt);
    bit armed;
    @(negedge clk);
    displayed   = tgt;
    snitch      = snt;
    start       = 1'b1;
    score_clear = clr_with_start;
    @(negedge clk);
    start       = 1'b0;
    score_clear = 1'b0;
    displayed   = ~tgt;  // target moves mid-round; the latched copy must be used
    done_at     = -1;
    rt_pulses   = 0;
    armed       = 1'b0;
    busy_seen   = busy;
    for (int i = 0; i < max_cyc; i++) begin
      if (i > 0) @(negedge clk);
      if (reset_trace) begin
        rt_pulses++;
        already = 16'h0000;
        armed   = 1'b1;
      end else if (armed) begin
        already = trc;
        armed   = 1'b0;
      end
      score_clear = (i == clr_at);
      if (round_done) begin
        done_at = i;
        break;
      end
    end
    score_clear = 1'b0;
    hold_cnt = 0;
    for (int i = 0; i < 50 && busy; i++) begin
      @(negedge clk);
      hold_cnt++;
    end
  endtask

  initial begin
    int  d;
    int  rt;
    bit  bs;
    int  hc;
    int  dones;
    n_cmp       = 0;
    n_err       = 0;
    rst_n       = 1'b0;
    start       = 1'b0;
    score_clear = 1'b0;
    displayed   = 16'h0000;
    already     = 16'h0000;
    snitch      = 16'h0000;
`ifdef TRACE_SCORER_SNITCH_BONUS_EN
    bonus = 15;
`else
    bonus = 10;
`endif

    #3;
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_reset_trace", 32'(reset_trace), 32'd0);
    chk("rst_round_done", 32'(round_done), 32'd0);
    chk("rst_hits", 32'(hits), 32'd0);
    chk("rst_misses", 32'(misses), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_score = 0;

    // Perfect round, stale trace present when the round starts.
    already = 16'h000F;
    run_round(16'h000F, 16'h000F, 16'h0000, 1'b0, -1, 20, d, rt, bs, hc);
    exp_score = sat_add(exp_score, 10);
    chk("perf_done_at", 32'(d), 32'd3);
    chk("perf_rt_pulses", 32'(rt), 32'd1);
    chk("perf_busy", 32'(bs), 32'd1);
    chk("perf_result", 32'(result), 32'd1);
    chk("perf_score", 32'(score), 32'(exp_score));
    chk("perf_hits", 32'(hits), 32'd4);
    chk("perf_misses", 32'(misses), 32'd0);
    chk("perf_hold", 32'(hc), HOLD);
    chk("perf_idle", 32'(busy), 32'd0);

    // Complete but one stray box.
    run_round(16'h0003, 16'h0007, 16'h0000, 1'b0, -1, 20, d, rt, bs, hc);
    exp_score = sat_add(exp_score, 5);
    chk("sloppy_done_at", 32'(d), 32'd3);
    chk("sloppy_result", 32'(result), 32'd2);
    chk("sloppy_score", 32'(score), 32'(exp_score));
    chk("sloppy_hits", 32'(hits), 32'd2);
    chk("sloppy_misses", 32'(misses), 32'd1);

    // Never completes: full ROUND-cycle window then timeout.
    run_round(16'h0003, 16'h0001, 16'h0000, 1'b0, -1, 300, d, rt, bs, hc);
    chk("tmo_done_at", 32'(d), 32'd102);
    chk("tmo_result", 32'(result), 32'd3);
    chk("tmo_score", 32'(score), 32'(exp_score));
    chk("tmo_hits", 32'(hits), 32'd1);
    chk("tmo_misses", 32'(misses), 32'd0);

    // Empty target skips tracing.
    run_round(16'h0000, 16'h0000, 16'h0000, 1'b0, -1, 20, d, rt, bs, hc);
    chk("empty_done_at", 32'(d), 32'd2);
    chk("empty_result", 32'(result), 32'd3);
    chk("empty_score", 32'(score), 32'(exp_score));

    // Snitch box traced in a perfect round.
    run_round(16'h8001, 16'h8001, 16'h8000, 1'b0, -1, 20, d, rt, bs, hc);
    exp_score = sat_add(exp_score, bonus);
    chk("snitch_result", 32'(result), 32'd1);
    chk("snitch_score", 32'(score), 32'(exp_score));

    // Clear in IDLE, then build up to 250 and saturate.
    @(negedge clk);
    score_clear = 1'b1;
    @(negedge clk);
    score_clear = 1'b0;
    exp_score = 0;
    chk("clear_idle", 32'(score), 32'd0);
    for (int k = 0; k < 25; k++) begin
      run_round(16'h000F, 16'h000F, 16'h0000, 1'b0, -1, 20, d, rt, bs, hc);
      exp_score = sat_add(exp_score, 10);
    end
    chk("preset_250", 32'(score), 32'(exp_score));
    run_round(16'h000F, 16'h000F, 16'h0000, 1'b0, -1, 20, d, rt, bs, hc);
    exp_score = sat_add(exp_score, 10);
    chk("saturate_255", 32'(score), 32'(exp_score));

    // Start and clear together: clear applies, round still runs and scores.
    run_round(16'h000F, 16'h000F, 16'h0000, 1'b1, -1, 20, d, rt, bs, hc);
    exp_score = 10;
    chk("clr_start_done", 32'(d), 32'd3);
    chk("clr_start_score", 32'(score), 32'(exp_score));

    // Clear in the SCORE cycle discards the round's points.
    run_round(16'h000F, 16'h000F, 16'h0000, 1'b0, 2, 20, d, rt, bs, hc);
    exp_score = 0;
    chk("clr_score_done", 32'(d), 32'd3);
    chk("clr_score_result", 32'(result), 32'd1);
    chk("clr_score_score", 32'(score), 32'(exp_score));

    // Asynchronous reset in the middle of TRACING.
    @(negedge clk);
    displayed = 16'h0003;
    start     = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    already = 16'h0000;
    @(negedge clk);
    already = 16'h0001;
    for (int k = 0; k < 10; k++) @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    chk("mid_hits", 32'(hits), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_hits", 32'(hits), 32'd0);
    chk("async_result", 32'(result), 32'd0);
    chk("async_score", 32'(score), 32'd0);
    chk("async_round_done", 32'(round_done), 32'd0);
    dones = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (round_done) dones++;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 120; k++) begin
      @(negedge clk);
      if (round_done) dones++;
    end
    chk("abandon_no_done", 32'(dones), 32'd0);
    chk("abandon_idle", 32'(busy), 32'd0);
    already = 16'h0000;
    run_round(16'h000F, 16'h000F, 16'h0000, 1'b0, -1, 20, d, rt, bs, hc);
    chk("post_rst_done", 32'(d), 32'd3);
    chk("post_rst_result", 32'(result), 32'd1);
    chk("post_rst_score", 32'(score), 32'd10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
